// File: rtl/countdown_cmd_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// countdown_cmd_scheduler_pkg
// Shared types for the countdown command stream: opcodes, command struct and
// the output-slot state encoding. The command struct is also consumed by the
// countdown core, so opcode values must stay fixed.
// -----------------------------------------------------------------------------
package countdown_cmd_scheduler_pkg;

  localparam int CMD_OP_W  = 3;
  localparam int CMD_ARG_W = 4;

  typedef enum logic [CMD_OP_W-1:0] {
    OP_NONE    = 3'd0,
    OP_START   = 3'd1,
    OP_CLEAR   = 3'd2,
    OP_NUM     = 3'd3,
    OP_CONFIRM = 3'd4,
    OP_TICK    = 3'd5
  } op_e;

  typedef struct packed {
    op_e                  op;
    logic [CMD_ARG_W-1:0] arg;
  } cmd_t;

  localparam cmd_t CMD_NONE = '{op: OP_NONE, arg: '0};
  localparam cmd_t CMD_TICK = '{op: OP_TICK, arg: '0};

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } slot_state_e;

endpackage

// File: rtl/countdown_cmd_scheduler_if.sv
// -----------------------------------------------------------------------------
// countdown_cmd_scheduler_if
// Valid/ready command stream from the scheduler to the countdown core.
//   cmd_valid  command present
//   cmd_ready  core accepts when cmd_valid && cmd_ready
//   cmd_op     opcode
//   cmd_arg    digit for OP_NUM, else 0
// master = scheduler side, slave = core side.
// -----------------------------------------------------------------------------
interface countdown_cmd_scheduler_if;
  import countdown_cmd_scheduler_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  op_e                  cmd_op;
  logic [CMD_ARG_W-1:0] cmd_arg;

  modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);

endinterface

// File: rtl/countdown_cmd_scheduler_cmd_fifo.sv
// -----------------------------------------------------------------------------
// cmd_fifo
// DEPTH-entry FIFO of cmd_t with synchronous push/pop. Pointers carry one
// extra wrap bit so full/empty come from an MSB compare. The caller only
// asserts i_push when there is room (or a pop happens in the same cycle), and
// only asserts i_pop when not empty.
// Ports:
//   clk, rst_n     clock, async active-low reset (empties the FIFO)
//   i_push         write i_push_data
//   i_push_data    command to store
//   i_pop          drop the head entry
//   o_head         head entry (valid when !o_empty)
//   o_full/o_empty occupancy flags
// -----------------------------------------------------------------------------
module cmd_fifo
  import countdown_cmd_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  cmd_t i_push_data,
  input  logic i_pop,
  output cmd_t o_head,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  cmd_t        r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset: contents are only observed behind the pointers.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_push_data;
  end

  assign o_head  = r_mem[r_rptr[AW-1:0]];
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_empty = (r_wptr == r_rptr);

endmodule

// File: rtl/countdown_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// countdown_cmd_scheduler
// Serialises keypad events and 1 s ticks into one ordered valid/ready command
// stream for the countdown core. Keys go through a small FIFO, ticks through a
// saturating pending counter; a single output slot picks pending ticks first.
// Every event reaches cmd_valid two cycles after it is presented (idle path).
//
// Optional feature macro: TICK_GEN_EN
//   defined   - internal prescaler generates the tick every TICK_DIV cycles,
//               i_tick_in ignored
//   undefined - i_tick_in is the tick, no prescaler
//
// Ports:
//   clk            system clock
//   rst_n          async active-low reset, discards all queued work
//   i_key_start    key pulses (one cycle each); when several arrive together
//   i_key_clear      the priority is clear > start > confirm > num and the
//   i_key_confirm    losers are counted as dropped
//   i_key_num
//   i_num          digit, sampled with i_key_num
//   i_tick_in      external 1 s tick pulse
//   cmd_if         command stream (master side)
//   o_overflow     sticky: some key or tick was lost
//   o_drop_cnt     saturating count of lost events
//
// Slot FSM:
//   state  | meaning
//   S_IDLE | slot empty, cmd_valid=0
//   S_HOLD | command presented, waiting for cmd_ready
// -----------------------------------------------------------------------------
module countdown_cmd_scheduler
  import countdown_cmd_scheduler_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int TICK_DIV    = 50000000,
  parameter int TICK_PEND_W = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_key_start,
  input  logic                           i_key_clear,
  input  logic                           i_key_confirm,
  input  logic                           i_key_num,
  input  logic [CMD_ARG_W-1:0]           i_num,
  input  logic                           i_tick_in,
  countdown_cmd_scheduler_if.master      cmd_if,
  output logic                           o_overflow,
  output logic [7:0]                     o_drop_cnt
);

  localparam logic [TICK_PEND_W-1:0] PEND_MAX = '1;

  // ---------------------------------------------------------------- tick source
  logic w_tick;

`ifdef TICK_GEN_EN
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_presc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_presc <= '0;
    else if (r_presc == PRESC_LAST) r_presc <= '0;
    else                          r_presc <= r_presc + 1'b1;
  end

  assign w_tick = (r_presc == PRESC_LAST);
`else
  // TICK_DIV has no effect without the internal prescaler.
  assign w_tick = i_tick_in && (TICK_DIV > 0);
`endif

  // ---------------------------------------------------------------- key select
  logic       w_key_any;
  logic [2:0] w_key_n;
  logic [2:0] w_key_drop;
  cmd_t       w_key_cmd;

  always_comb begin
    w_key_cmd = CMD_NONE;
    if (i_key_clear)        w_key_cmd.op = OP_CLEAR;
    else if (i_key_start)   w_key_cmd.op = OP_START;
    else if (i_key_confirm) w_key_cmd.op = OP_CONFIRM;
    else if (i_key_num) begin
      w_key_cmd.op  = OP_NUM;
      w_key_cmd.arg = i_num;
    end
  end

  assign w_key_any  = i_key_start | i_key_clear | i_key_confirm | i_key_num;
  assign w_key_n    = 3'(i_key_start) + 3'(i_key_clear) + 3'(i_key_confirm) + 3'(i_key_num);
  assign w_key_drop = w_key_any ? (w_key_n - 3'd1) : 3'd0;

  // ---------------------------------------------------------------- FIFO
  logic r_cmd_valid;
  cmd_t r_cmd;
  slot_state_e r_state;
  logic [TICK_PEND_W-1:0] r_pend;

  logic w_load;
  logic w_pend_nz;
  logic w_pop;
  logic w_push;
  logic w_fifo_full;
  logic w_fifo_empty;
  cmd_t w_fifo_head;

  assign w_load    = !r_cmd_valid || cmd_if.cmd_ready;
  assign w_pend_nz = (r_pend != '0);
  // Ticks win the slot; the FIFO only drains when no tick is waiting.
  assign w_pop     = w_load && !w_pend_nz && !w_fifo_empty;
  // A pop in the same cycle frees the entry the push needs.
  assign w_push    = w_key_any && (!w_fifo_full || w_pop);

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_key_cmd),
    .i_pop       (w_pop),
    .o_head      (w_fifo_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  // ---------------------------------------------------------------- pending ticks
  logic w_tick_take;
  logic w_tick_acc;
  logic w_tick_drop;

  assign w_tick_take = w_load && w_pend_nz;
  // A tick arriving at saturation survives only if one leaves in the same cycle.
  assign w_tick_acc  = w_tick && (w_tick_take || (r_pend != PEND_MAX));
  assign w_tick_drop = w_tick && !w_tick_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_pend <= '0;
    else if (w_tick_acc && !w_tick_take) r_pend <= r_pend + 1'b1;
    else if (!w_tick_acc && w_tick_take) r_pend <= r_pend - 1'b1;
  end

  // ---------------------------------------------------------------- drop accounting
  logic [2:0] w_drops;
  logic [8:0] w_drop_sum;
  logic       r_overflow;
  logic [7:0] r_drop_cnt;

  assign w_drops    = w_key_drop + 3'(w_key_any && !w_push) + 3'(w_tick_drop);
  assign w_drop_sum = {1'b0, r_drop_cnt} + {6'd0, w_drops};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_drops != 3'd0) r_overflow <= 1'b1;
      r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

  // ---------------------------------------------------------------- output slot
  logic w_src_valid;
  cmd_t w_src_cmd;

  assign w_src_valid = w_pend_nz || !w_fifo_empty;
  assign w_src_cmd   = w_pend_nz ? CMD_TICK : w_fifo_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cmd_valid <= 1'b0;
      r_cmd       <= CMD_NONE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_src_valid) begin
            r_state     <= S_HOLD;
            r_cmd_valid <= 1'b1;
            r_cmd       <= w_src_cmd;
          end
        end
        S_HOLD: begin
          if (cmd_if.cmd_ready) begin
            if (w_src_valid) begin
              r_cmd <= w_src_cmd;
            end else begin
              r_state     <= S_IDLE;
              r_cmd_valid <= 1'b0;
              r_cmd       <= CMD_NONE;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cmd_valid <= 1'b0;
          r_cmd       <= CMD_NONE;
        end
      endcase
    end
  end

  assign cmd_if.cmd_valid = r_cmd_valid;
  assign cmd_if.cmd_op    = r_cmd.op;
  assign cmd_if.cmd_arg   = r_cmd.arg;
  assign o_overflow       = r_overflow;
  assign o_drop_cnt       = r_drop_cnt;

endmodule

// File: tb/tb_countdown_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// tb_countdown_cmd_scheduler
// Directed stimulus with a scoreboard queue of expected commands; a monitor
// compares the presented command against the queue head on every falling edge
// while cmd_valid is high and retires the entry on a handshake.
// Build with TICK_GEN_EN defined to exercise the internal prescaler.
// -----------------------------------------------------------------------------
module tb_countdown_cmd_scheduler;
  import countdown_cmd_scheduler_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       k_start, k_clear, k_confirm, k_num;
  logic [3:0] num;
  logic       tick_in;
  logic       overflow;
  logic [7:0] drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  cmd_t q[$];

  countdown_cmd_scheduler_if cif ();

  countdown_cmd_scheduler #(.DEPTH(4), .TICK_DIV(10), .TICK_PEND_W(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_key_start   (k_start),
    .i_key_clear   (k_clear),
    .i_key_confirm (k_confirm),
    .i_key_num     (k_num),
    .i_num         (num),
    .i_tick_in     (tick_in),
    .cmd_if        (cif.master),
    .o_overflow    (overflow),
    .o_drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic void expect_cmd(input op_e op, input int arg);
    cmd_t c;
    c.op  = op;
    c.arg = 4'(arg);
    q.push_back(c);
  endfunction

  // One key for one cycle, then all keys low.
  task automatic key(input op_e op, input int arg);
    case (op)
      OP_START:   k_start   = 1'b1;
      OP_CLEAR:   k_clear   = 1'b1;
      OP_CONFIRM: k_confirm = 1'b1;
      OP_NUM: begin
        k_num = 1'b1;
        num   = 4'(arg);
      end
      default: ;
    endcase
    step(1);
    {k_start, k_clear, k_confirm, k_num} = 4'b0;
    num = 4'd0;
  endtask

  task automatic tick_pulse();
    tick_in = 1'b1;
    step(1);
    tick_in = 1'b0;
  endtask

  // Leaves the bench at the start of cycle 0 after reset release.
  task automatic reset_dut();
    {k_start, k_clear, k_confirm, k_num} = 4'b0;
    num     = 4'd0;
    tick_in = 1'b0;
    rst_n   = 1'b0;
    q.delete();
    step(2);
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && cif.cmd_valid) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_cmd: got op %0d arg %0d, required no command (t=%0t)",
                 cif.cmd_op, cif.cmd_arg, $time);
      end else begin
        chk("cmd_op", int'(cif.cmd_op), int'(q[0].op));
        chk("cmd_arg", int'(cif.cmd_arg), int'(q[0].arg));
        if (cif.cmd_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ops[5];
    int args[5];
    ops  = '{int'(OP_START), int'(OP_NUM), int'(OP_CONFIRM), int'(OP_NUM), int'(OP_CLEAR)};
    args = '{0, 2, 0, 9, 0};

    rst_n = 1'b0;
    cif.cmd_ready = 1'b0;
    {k_start, k_clear, k_confirm, k_num} = 4'b0;
    num = 4'd0;
    tick_in = 1'b0;
    #3;
    chk("rst_valid", int'(cif.cmd_valid), 0);
    chk("rst_op", int'(cif.cmd_op), int'(OP_NONE));
    chk("rst_arg", int'(cif.cmd_arg), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_drop_cnt", int'(drop_cnt), 0);
    reset_dut();

`ifdef TICK_GEN_EN
    // Prescaler ticks in cycles 9, 19, 29 -> cmd_valid in cycles 11, 21, 31.
    cif.cmd_ready = 1'b1;
    expect_cmd(OP_TICK, 0);
    expect_cmd(OP_TICK, 0);
    expect_cmd(OP_TICK, 0);
    for (int c = 0; c < 33; c++) begin
      tick_in = (c == 3);
      @(negedge clk);
      chk($sformatf("gen_valid_c%0d", c), int'(cif.cmd_valid),
          int'(c == 11 || c == 21 || c == 31));
      @(posedge clk);
      #1;
    end
    tick_in = 1'b0;
    chk("gen_drained", q.size(), 0);

    // Async reset while stalled (cycles 33.. before the tick in cycle 39).
    cif.cmd_ready = 1'b0;
    expect_cmd(OP_START, 0);
    key(OP_START, 0);
    key(OP_NUM, 6);
    @(negedge clk);
    chk("gen_stall_valid", int'(cif.cmd_valid), 1);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("gen_async_valid", int'(cif.cmd_valid), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cif.cmd_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      chk($sformatf("gen_flushed_c%0d", c), int'(cif.cmd_valid), 0);
      @(posedge clk);
      #1;
    end
    expect_cmd(OP_TICK, 0);
    step(4);
    chk("gen_tick_after_rst", q.size(), 0);
`else
    // 1: key_start in cycle 5 -> valid in cycle 7 only.
    cif.cmd_ready = 1'b1;
    step(5);
    expect_cmd(OP_START, 0);
    key(OP_START, 0);
    @(negedge clk);
    chk("t1_valid_c6", int'(cif.cmd_valid), 0);
    step(1);
    @(negedge clk);
    chk("t1_valid_c7", int'(cif.cmd_valid), 1);
    chk("t1_op_c7", int'(cif.cmd_op), int'(OP_START));
    step(1);
    @(negedge clk);
    chk("t1_valid_c8", int'(cif.cmd_valid), 0);
    step(1);

    // 2: num 7 then 3 on consecutive cycles -> back-to-back commands.
    expect_cmd(OP_NUM, 7);
    expect_cmd(OP_NUM, 3);
    k_num = 1'b1;
    num   = 4'd7;
    step(1);
    num   = 4'd3;
    step(1);
    k_num = 1'b0;
    num   = 4'd0;
    @(negedge clk);
    chk("t2_valid_a", int'(cif.cmd_valid), 1);
    chk("t2_arg_a", int'(cif.cmd_arg), 7);
    step(1);
    @(negedge clk);
    chk("t2_valid_b", int'(cif.cmd_valid), 1);
    chk("t2_arg_b", int'(cif.cmd_arg), 3);
    step(1);
    @(negedge clk);
    chk("t2_valid_end", int'(cif.cmd_valid), 0);
    step(1);

    // 3: clear and num together -> only clear, one drop.
    expect_cmd(OP_CLEAR, 0);
    k_clear = 1'b1;
    k_num   = 1'b1;
    num     = 4'd5;
    step(1);
    {k_clear, k_num} = 2'b0;
    num = 4'd0;
    step(4);
    chk("t3_drop_cnt", int'(drop_cnt), 1);
    chk("t3_overflow", int'(overflow), 1);
    chk("t3_drained", q.size(), 0);

    // 4: stalled, 5 keys fit (slot + 4 FIFO), 6th dropped, then drain in order.
    reset_dut();
    cif.cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_cmd(op_e'(ops[i]), args[i]);
      key(op_e'(ops[i]), args[i]);
    end
    step(2);
    chk("t4_drop_5keys", int'(drop_cnt), 0);
    chk("t4_overflow_5keys", int'(overflow), 0);
    key(OP_START, 0);
    step(2);
    chk("t4_drop_6th", int'(drop_cnt), 1);
    chk("t4_overflow_6th", int'(overflow), 1);
    step(3);
    cif.cmd_ready = 1'b1;
    step(8);
    chk("t4_drained", q.size(), 0);
    chk("t4_valid_end", int'(cif.cmd_valid), 0);

    // 5a: queued keys plus a tick -> tick overtakes the FIFO.
    reset_dut();
    cif.cmd_ready = 1'b0;
    expect_cmd(OP_CONFIRM, 0);
    key(OP_CONFIRM, 0);
    step(2);
    key(OP_START, 0);
    key(OP_NUM, 4);
    tick_pulse();
    expect_cmd(OP_TICK, 0);
    expect_cmd(OP_START, 0);
    expect_cmd(OP_NUM, 4);
    step(2);
    cif.cmd_ready = 1'b1;
    step(6);
    chk("t5a_drained", q.size(), 0);
    chk("t5a_drop_cnt", int'(drop_cnt), 0);

    // 5b: slot occupied, 4 ticks -> 3 pending, 1 dropped; tick+pop nets zero.
    reset_dut();
    cif.cmd_ready = 1'b0;
    expect_cmd(OP_START, 0);
    key(OP_START, 0);
    step(2);
    repeat (4) tick_pulse();
    step(2);
    chk("t5b_drop_cnt", int'(drop_cnt), 1);
    chk("t5b_overflow", int'(overflow), 1);
    repeat (4) expect_cmd(OP_TICK, 0);
    cif.cmd_ready = 1'b1;
    tick_in = 1'b1;
    step(1);
    tick_in = 1'b0;
    step(8);
    chk("t5b_drop_after_pop", int'(drop_cnt), 1);
    chk("t5b_drained", q.size(), 0);

    // drop_cnt saturation: all four keys held with ready low.
    reset_dut();
    cif.cmd_ready = 1'b0;
    repeat (5) expect_cmd(OP_CLEAR, 0);
    {k_start, k_clear, k_confirm, k_num} = 4'b1111;
    num = 4'd1;
    step(1);
    @(negedge clk);
    chk("sat_first_cycle", int'(drop_cnt), 3);
    step(99);
    {k_start, k_clear, k_confirm, k_num} = 4'b0;
    num = 4'd0;
    step(1);
    chk("sat_drop_cnt", int'(drop_cnt), 255);
    cif.cmd_ready = 1'b1;
    step(8);
    chk("sat_drained", q.size(), 0);
    chk("sat_drop_hold", int'(drop_cnt), 255);

    // Async reset mid-stall discards slot and FIFO.
    cif.cmd_ready = 1'b0;
    expect_cmd(OP_START, 0);
    key(OP_START, 0);
    key(OP_CONFIRM, 0);
    key(OP_NUM, 6);
    step(1);
    @(negedge clk);
    chk("ar_stall_valid", int'(cif.cmd_valid), 1);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("ar_async_valid", int'(cif.cmd_valid), 0);
    chk("ar_async_op", int'(cif.cmd_op), int'(OP_NONE));
    chk("ar_async_drop", int'(drop_cnt), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cif.cmd_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("ar_flushed_c%0d", c), int'(cif.cmd_valid), 0);
      @(posedge clk);
      #1;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
